// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit -- single-issue 8-bit execution unit with register-file writeback.
//
// Accepts one instruction per cycle (issue_valid && issue_ready), computes an
// 8-bit ALU result and writes it back through a registered write port in the
// following cycle. MUL is an optional 8-cycle shift-add multiplier.
//
// Configuration macro:
//   EXEC_MUL_EN  defined   -> op 111 is a multi-cycle MUL (low byte of opa*opb)
//                undefined -> op 111 is a NOP (goes to WB, no write, no flag change)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   issue_valid  instruction offered
//   issue_ready  unit accepts an instruction this cycle
//   op, dst      opcode and destination register address
//   opa, opb     operands from register file read ports a and b
//   reg_write    one-cycle register file write strobe
//   write_addr   write address (holds when reg_write is low)
//   write_data   write data (holds when reg_write is low)
//   flag_z       result was zero
//   flag_c       carry / borrow / shifted-out bit / MUL overflow
//   busy         state is not IDLE
// -----------------------------------------------------------------------------
module exec_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [2:0] op,
    input  logic [2:0] dst,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    output logic       reg_write,
    output logic [2:0] write_addr,
    output logic [7:0] write_data,
    output logic       flag_z,
    output logic       flag_c,
    output logic       busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_WB = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd2} state_t;
`endif

    state_t     state, state_next;
    logic       accept;
    logic [7:0] alu_res;
    logic       alu_c;

    assign accept = issue_valid && issue_ready;

    // Single-cycle ALU, evaluated on the live operands at the accept edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        alu_res = 8'h00;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  begin
                         alu_res = opa - opb;
                         alu_c   = (opa < opb);
                     end
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SHL:  begin
                         alu_res = {opa[6:0], 1'b0};
                         alu_c   = opa[7];
                     end
            OP_SHR:  begin
                         alu_res = {1'b0, opa[7:1]};
                         alu_c   = opa[0];
                     end
            default: ;  // OP_MUL: handled by the multiplier or treated as NOP
        endcase
    end

`ifdef EXEC_MUL_EN
    // Shift-add multiplier: one partial product per cycle while in S_MUL.
    logic [15:0] mcand;
    logic [15:0] acc;
    logic [15:0] mul_sum;
    logic [7:0]  mplier;
    logic [2:0]  mul_cnt;
    logic [2:0]  mul_dst;
    logic        mul_done;

    assign mul_sum  = acc + (mplier[0] ? mcand : 16'h0000);
    assign mul_done = (state == S_MUL) && (mul_cnt == 3'd7);

    // NOTE: working registers carry no reset; they are always loaded at accept before S_MUL reads them.
    always_ff @(posedge clk) begin
        if (accept && op == OP_MUL) begin
            mcand   <= {8'h00, opa};
            mplier  <= opb;
            acc     <= 16'h0000;
            mul_cnt <= 3'd0;
            mul_dst <= dst;
        end else if (state == S_MUL) begin
            acc     <= mul_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 3'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE, S_WB: begin
                if (accept) begin
`ifdef EXEC_MUL_EN
                    state_next = (op == OP_MUL) ? S_MUL : S_WB;
`else
                    state_next = S_WB;
`endif
                end
            end
`ifdef EXEC_MUL_EN
            S_MUL: state_next = (mul_cnt == 3'd7) ? S_WB : S_MUL;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; the unit never offers ready while rst is high.
    always_comb begin
`ifdef EXEC_MUL_EN
        issue_ready = !rst && (state != S_MUL);
`else
        issue_ready = !rst;
`endif
        busy = (state != S_IDLE);
    end

    // Writeback port and flags; loaded only on the edge entering WB with a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_addr <= 3'd0;
            write_data <= 8'h00;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            if (accept && op != OP_MUL) begin
                reg_write  <= 1'b1;
                write_addr <= dst;
                write_data <= alu_res;
                flag_z     <= (alu_res == 8'h00);
                flag_c     <= alu_c;
            end
`ifdef EXEC_MUL_EN
            if (mul_done) begin
                reg_write  <= 1'b1;
                write_addr <= mul_dst;
                write_data <= mul_sum[7:0];
                flag_z     <= (mul_sum[7:0] == 8'h00);
                flag_c     <= |mul_sum[15:8];
            end
`endif
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit -- table-driven self-checking bench for exec_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. reflecting the edge just taken. Follows EXEC_MUL_EN.
// -----------------------------------------------------------------------------
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] op;
    logic [2:0] dst;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       reg_write;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic       flag_z;
    logic       flag_c;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    exec_unit dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .op          (op),
        .dst         (dst),
        .opa         (opa),
        .opb         (opb),
        .reg_write   (reg_write),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] dst;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [7:0] exp_data;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {reg_write, write_addr, write_data, flag_z, flag_c}
    function automatic logic [13:0] outs();
        return {reg_write, write_addr, write_data, flag_z, flag_c};
    endfunction

    initial begin
        //                op      dst   opa    opb    data   z     c
        vecs[0]  = '{3'b000, 3'd3, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1}; // ADD carry
        vecs[1]  = '{3'b001, 3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0}; // SUB equal
        vecs[2]  = '{3'b001, 3'd2, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b1}; // SUB borrow
        vecs[3]  = '{3'b010, 3'd4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0}; // AND
        vecs[4]  = '{3'b011, 3'd5, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0}; // OR
        vecs[5]  = '{3'b100, 3'd6, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0}; // XOR zero
        vecs[6]  = '{3'b101, 3'd7, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1}; // SHL out bit
        vecs[7]  = '{3'b110, 3'd0, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1}; // SHR out bit
        vecs[8]  = '{3'b000, 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1}; // ADD wrap
        vecs[9]  = '{3'b100, 3'd2, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0}; // XOR  } back
        vecs[10] = '{3'b011, 3'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0}; // OR   } to
        vecs[11] = '{3'b101, 3'd4, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0}; // SHL  } back
        vecs[12] = '{3'b110, 3'd5, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1}; // SHR to zero

        // ---- reset state, with an instruction offered during reset ----
        rst = 1'b1; issue_valid = 1'b1; op = 3'b000; dst = 3'd7; opa = 8'h11; opb = 8'h22;
        tick();
        tick();
        check("reset_outputs", {18'd0, outs()}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready_low", {31'd0, issue_ready}, 32'd0);
        rst = 1'b0; issue_valid = 1'b0;
        #1;
        check("post_reset_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        check("discarded_no_write", {31'd0, reg_write}, 32'd0);

        // ---- table: all vectors issued back to back ----
        for (int i = 0; i < 13; i++) begin
            issue_valid = 1'b1;
            op  = vecs[i].op;  dst = vecs[i].dst;
            opa = vecs[i].opa; opb = vecs[i].opb;
            #1;
            check($sformatf("vec%0d_ready", i), {31'd0, issue_ready}, 32'd1);
            tick();
            check($sformatf("vec%0d_wb", i), {18'd0, outs()},
                  {18'd0, 1'b1, vecs[i].dst, vecs[i].exp_data, vecs[i].exp_z, vecs[i].exp_c});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
        end
        issue_valid = 1'b0;
        opa = 8'h99; opb = 8'h77;
        tick();
        // Port holds last values; flags from vecs[12] (z=1, c=1).
        check("idle_hold", {18'd0, outs()}, {18'd0, 1'b0, 3'd5, 8'h00, 1'b1, 1'b1});
        check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef EXEC_MUL_EN
        // ---- MUL 0x12 * 0x10 = 0x0120 -> data 0x20, c=1, z=0, 8-cycle stall ----
        issue_valid = 1'b1; op = 3'b111; dst = 3'd6; opa = 8'h12; opb = 8'h10;
        tick();
        op = 3'b000; opa = 8'hFF; opb = 8'hFF; dst = 3'd1;  // ignored while multiplying
        for (int k = 0; k < 8; k++) begin
            check($sformatf("mul_stall%0d", k), {29'd0, issue_ready, reg_write, busy}, 32'b001);
            if (k < 7) tick();
        end
        issue_valid = 1'b0;
        tick();
        check("mul_wb", {18'd0, outs()}, {18'd0, 1'b1, 3'd6, 8'h20, 1'b0, 1'b1});
        check("mul_wb_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        check("mul_single_pulse", {31'd0, reg_write}, 32'd0);

        // ---- reset 4 cycles into a MUL: abandoned ----
        issue_valid = 1'b1; op = 3'b111; dst = 3'd2; opa = 8'h03; opb = 8'h05;
        tick();
        issue_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mulrst_outputs", {18'd0, outs()}, 32'd0);
        check("mulrst_busy_ready", {30'd0, busy, issue_ready}, 32'b01);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("mulrst_nowrite%0d", k), {31'd0, reg_write}, 32'd0);
        end
`else
        // ---- op 111 without the multiplier: NOP through WB ----
        issue_valid = 1'b1; op = 3'b111; dst = 3'd6; opa = 8'h12; opb = 8'h10;
        tick();
        issue_valid = 1'b0;
        check("nop_wb", {18'd0, outs()}, {18'd0, 1'b0, 3'd5, 8'h00, 1'b1, 1'b1});
        check("nop_busy_ready", {30'd0, busy, issue_ready}, 32'b11);
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("nop_nowrite%0d", k), {31'd0, reg_write}, 32'd0);
        end

        // ---- reset during WB: no further write, outputs cleared ----
        issue_valid = 1'b1; op = 3'b000; dst = 3'd2; opa = 8'h01; opb = 8'h01;
        tick();
        issue_valid = 1'b1; op = 3'b001; dst = 3'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0; issue_valid = 1'b0;
        #1;
        check("wbrst_outputs", {18'd0, outs()}, 32'd0);
        check("wbrst_busy_ready", {30'd0, busy, issue_ready}, 32'b01);
        tick();
        check("wbrst_nowrite", {31'd0, reg_write}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
